// File: rtl/spi_master_ctrl.sv
// SPI frame sequencer: pre-LOAD, W full-duplex bits MSB first, post-LOAD.
// Every output is a flop loaded from the next-state decode, so pins change only on clk.
module spi_master_ctrl #(
    parameter int W   = 15,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         st,
    input  logic [W-1:0] DI,
    output logic [W-1:0] DO,
    output logic         busy,
    output logic         done,
    output logic         SCLK,
    output logic         MOSI,
    output logic         LOAD,
    input  logic         MISO
);

    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(W);
    localparam logic [HW-1:0] HC_LAST = HW'(DIV - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(W - 1);

    typedef enum logic [2:0] {IDLE, PRE, SHL, SHH, POST, FIN} state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hc, hc_n;
    logic [BW-1:0]  bc, bc_n;
    logic [W-1:0]   tx_sr, tx_n;
    logic [W-1:0]   rx_sr, rx_n;
    logic [W-1:0]   do_n;
    logic           hc_last;

    assign hc_last = (hc == HC_LAST);

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_n = state;
        hc_n    = hc;
        bc_n    = bc;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        do_n    = DO;
        unique case (state)
            IDLE, FIN: begin
                // A start seen during FIN chains the next frame with no idle gap.
                if (st) begin
                    tx_n    = DI;
                    rx_n    = '0;
                    hc_n    = '0;
                    bc_n    = '0;
                    state_n = PRE;
                end else begin
                    state_n = IDLE;
                end
            end
            PRE: begin
                hc_n = hc + 1'b1;
                if (hc_last) begin
                    hc_n    = '0;
                    state_n = SHL;
                end
            end
            SHL: begin
                hc_n = hc + 1'b1;
                if (hc_last) begin
                    hc_n    = '0;
                    rx_n    = {rx_sr[W-2:0], MISO};
                    state_n = SHH;
                end
            end
            SHH: begin
                hc_n = hc + 1'b1;
                if (hc_last) begin
                    hc_n = '0;
                    tx_n = {tx_sr[W-2:0], 1'b0};
                    if (bc == BC_LAST) begin
                        bc_n    = '0;
                        state_n = POST;
                    end else begin
                        bc_n    = bc + 1'b1;
                        state_n = SHL;
                    end
                end
            end
            POST: begin
                hc_n = hc + 1'b1;
                if (hc_last) begin
                    hc_n    = '0;
                    do_n    = rx_sr;
                    state_n = FIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            hc    <= '0;
            bc    <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            DO    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            SCLK  <= 1'b0;
            MOSI  <= 1'b0;
            LOAD  <= 1'b0;
        end else begin
            state <= state_n;
            hc    <= hc_n;
            bc    <= bc_n;
            tx_sr <= tx_n;
            rx_sr <= rx_n;
            DO    <= do_n;
            busy  <= (state_n == PRE) || (state_n == SHL) || (state_n == SHH) || (state_n == POST);
            done  <= (state_n == FIN);
            SCLK  <= (state_n == SHH);
            LOAD  <= (state_n == PRE) || (state_n == POST);
            // MOSI only moves on the SHH->SHL edge, i.e. while SCLK is low.
            MOSI  <= ((state_n == SHL) || (state_n == SHH)) ? tx_n[W-1] : 1'b0;
        end
    end

endmodule
